axil_read_burst: RTL and testbench
==================================

# axil_read_burst

Parametrised AXI4-Lite read master that turns one command (base address, beat count) into a sequence of single-beat AXI-Lite reads at consecutive word addresses. Up to MAX_OUTSTANDING reads may be in flight. Returned data is forwarded on a valid/ready output stream with a last flag. It replaces the fixed single-read, single-address reader and connects directly to the `s_axil_*` port set of the team's `axi_ram`.

## Interface
Parameters:
- ADDR_WIDTH, 16, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- COUNT_WIDTH, 8, width of the beat-count field.
- MAX_OUTSTANDING, 4, maximum number of accepted ARs without a returned R; must be 1..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- start_valid  input  1  command valid.
- start_ready  output  1  command ready; high only in IDLE.
- start_addr  input  ADDR_WIDTH  base byte address.
- start_count  input  COUNT_WIDTH  number of reads.
- s_axil_araddr  output  ADDR_WIDTH  read address.
- s_axil_arprot  output  3  tied to 0.
- s_axil_arvalid  output  1  AR valid.
- s_axil_arready  input  1  AR ready.
- s_axil_rdata  input  DATA_WIDTH  read data.
- s_axil_rresp  input  2  read response.
- s_axil_rvalid  input  1  R valid.
- s_axil_rready  output  1  R ready.
- out_data  output  DATA_WIDTH  returned word.
- out_resp  output  2  rresp of that word.
- out_last  output  1  final beat of the command.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer ready.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse at command completion.
- err  output  1  sticky: any non-OKAY rresp in the current or last command; cleared on command accept.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: start_ready=1. On start_valid, latch addr and count, clear err, and go to RUN. If count==0, go to FIN instead.
- RUN, AR side:
  - arvalid is registered.
  - While issued<count and outstanding<MAX_OUTSTANDING, present arvalid with araddr = base + issued*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
  - araddr and arvalid hold stable until arready.
  - On handshake: issued++ and outstanding++. The next AR may be presented in the following cycle.
- RUN, R side:
  - rready = !out_valid || out_ready (single-entry output register, full throughput).
  - On handshake: outstanding--, received++, and the word is loaded into the output register.
  - out_last = (received+1==count).
  - A simultaneous AR and R handshake leaves outstanding unchanged.
- RUN→FIN when the last output beat handshakes (out_valid && out_ready && out_last).
- FIN: done=1 for one cycle, then IDLE.
- Non-OKAY rresp (1x) sets err; behaviour beyond that is per Configuration.
- Reset values: state IDLE; start_ready=1 after reset release; arvalid, out_valid, out_last, done, err, busy, araddr, out_data, out_resp all 0. rready reads 1 (output register empty).
- Reset mid-command aborts immediately. Outstanding slave responses are the integrator's responsibility.

## Timing
- Start accepted at cycle T → first arvalid at T+1.
- R handshake at U → out_valid at U+1.
- Zero-wait slave with out_ready held high: one beat per cycle. A slave with arready and rvalid asserted back-to-back finishes count=N in N+2 cycles from start accept to last out handshake.
- done asserts in the cycle after the last out handshake. start_ready returns the cycle after done.
- count==0: done at T+1, no AR issued.

## Configuration
- AXIL_READ_ERR_ABORT_EN defined:
  - The first non-OKAY rresp stops further AR issue.
  - That beat is forwarded with out_last=1.
  - Remaining outstanding R beats are accepted with rready=1 and discarded, not forwarded.
  - Once outstanding==0 and the error beat has handshaken, go to FIN. err=1.
- Undefined: every beat is forwarded, count always completes, and err only flags.

## Test plan
- addr=0x0100, count=4, zero-wait slave, rdata 0xA0..0xA3, out_ready=1 → araddr 0x100/0x104/0x108/0x10C; out_data 0xA0..0xA3; out_last on 0xA3; done one cycle later; err=0.
- addr=0xFFFC, count=2 → araddr 0xFFFC then 0x0000.
- count=0 → done at T+1, arvalid never high, busy high one cycle.
- count=8, arready=1, rvalid=0 for 20 cycles → exactly 4 AR handshakes, then arvalid=0. Releasing rvalid yields 8 beats in order.
- out_ready=0 for 5 cycles after the first beat → out_data holds 0xA0, rready=0, no beat lost. Remaining beats arrive in order after release.
- count=4, rresp=2 on beat 2:
  - with macro → beats 1 and 2 out, beat 2 out_last=1, no third AR once the error is seen, err=1, done.
  - without macro → 4 beats out, err=1.
- Reset pulled low while count=8 is in RUN → arvalid, out_valid and busy drop to 0 the same cycle. A new command afterwards runs cleanly.

Source files
------------

// File: rtl/axil_read_burst.sv
// axil_read_burst: AXI4-Lite read master issuing count single-beat reads from a base address, up to MAX_OUTSTANDING in flight.
// Ports: clk/rst (async active-low); start_* command handshake; s_axil_ar*/r* AXI-Lite read channels;
// out_* valid/ready result stream with last flag; busy, done pulse, sticky err.
// Optional: define AXIL_READ_ERR_ABORT_EN to stop a command at its first non-OKAY response.
module axil_read_burst #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int COUNT_WIDTH     = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [COUNT_WIDTH-1:0] start_count,
    output logic [ADDR_WIDTH-1:0]  s_axil_araddr,
    output logic [2:0]             s_axil_arprot,
    output logic                   s_axil_arvalid,
    input  logic                   s_axil_arready,
    input  logic [DATA_WIDTH-1:0]  s_axil_rdata,
    input  logic [1:0]             s_axil_rresp,
    input  logic                   s_axil_rvalid,
    output logic                   s_axil_rready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [1:0]             out_resp,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int SHIFT = (DATA_WIDTH == 64) ? 3 : 2;
`ifdef AXIL_READ_ERR_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d, araddr_q, araddr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d, issued_q, issued_d, received_q, received_d;
    logic [3:0]             outst_q, outst_d;
    logic                   arvalid_q, arvalid_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                   err_q, err_d, abort_q, abort_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [1:0]             out_resp_q, out_resp_d;
    logic                   ar_hs, r_hs, out_hs, keep, ar_hold;

    assign start_ready    = state_q == IDLE;
    assign busy           = state_q != IDLE;
    assign done           = state_q == FIN;
    assign err            = err_q;
    assign s_axil_araddr  = araddr_q;
    assign s_axil_arprot  = 3'b000;
    assign s_axil_arvalid = arvalid_q;
    // Once aborted, leftover responses are drained and dropped regardless of the consumer.
    assign s_axil_rready  = abort_q || !out_valid_q || out_ready;
    assign out_data       = out_data_q;
    assign out_resp       = out_resp_q;
    assign out_last       = out_last_q;
    assign out_valid      = out_valid_q;

    assign ar_hs   = arvalid_q && s_axil_arready;
    assign ar_hold = arvalid_q && !s_axil_arready;
    assign r_hs    = state_q == RUN && s_axil_rvalid && s_axil_rready;
    assign out_hs  = out_valid_q && out_ready;
    assign keep    = r_hs && !abort_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        issued_d    = issued_q;
        received_d  = received_q;
        outst_d     = outst_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_resp_d  = out_resp_q;
        err_d       = err_q;
        abort_d     = abort_q;
        case (state_q)
            IDLE: if (start_valid) begin
                base_d     = start_addr;
                count_d    = start_count;
                araddr_d   = start_addr;
                arvalid_d  = start_count != '0;
                issued_d   = '0;
                received_d = '0;
                outst_d    = '0;
                err_d      = 1'b0;
                abort_d    = 1'b0;
                state_d    = start_count == '0 ? FIN : RUN;
            end
            RUN: begin
                issued_d = issued_q + COUNT_WIDTH'(ar_hs);
                outst_d  = outst_q + 4'(ar_hs) - 4'(r_hs);
                if (r_hs && s_axil_rresp[1]) begin
                    err_d   = 1'b1;
                    abort_d = ABORT_EN;
                end
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (keep) begin
                    out_valid_d = 1'b1;
                    out_data_d  = s_axil_rdata;
                    out_resp_d  = s_axil_rresp;
                    out_last_d  = (received_q + COUNT_WIDTH'(1) == count_q) || (ABORT_EN && s_axil_rresp[1]);
                    received_d  = received_q + COUNT_WIDTH'(1);
                end
                // A presented AR must stay put until accepted, even after an abort.
                arvalid_d = ar_hold || (issued_d < count_q && outst_d < 4'(MAX_OUTSTANDING) && !abort_d);
                araddr_d  = ar_hold ? araddr_q : base_q + (ADDR_WIDTH'(issued_d) << SHIFT);
                if (abort_d ? (outst_d == '0 && !arvalid_d && !out_valid_d) : (out_hs && out_last_q))
                    state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            outst_q     <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_resp_q  <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            outst_q     <= outst_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_resp_q  <= out_resp_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
        end
    end
endmodule

// File: tb/tb_axil_read_burst.sv
// tb_axil_read_burst: scoreboard bench for axil_read_burst with a one-cycle-latency AXI-Lite slave model.
module tb_axil_read_burst;
    logic        clk = 1'b0, rst = 1'b0;
    logic        start_valid = 1'b0, start_ready;
    logic [15:0] start_addr = '0;
    logic [7:0]  start_count = '0;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready = 1'b1;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0, rready;
    logic [31:0] out_data;
    logic [1:0]  out_resp;
    logic        out_last, out_valid, out_ready = 1'b1;
    logic        busy, done, err;

    always #5 clk = ~clk;

    axil_read_burst #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .COUNT_WIDTH(8), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_addr(start_addr), .start_count(start_count),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .out_data(out_data), .out_resp(out_resp), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {logic [31:0] d; logic [1:0] r; logic l;} beat_t;
    beat_t       exp_out[$];
    logic [15:0] exp_ar[$];
    logic [15:0] cur_base = '0;
    int          err_idx = -1, ar_cnt = 0, ar_after_err = 0;
    bit          ar_chk = 1'b1, r_en = 1'b1;

    function automatic int idx(input logic [15:0] a);
        logic [15:0] off;
        off = a - cur_base;
        return int'(off >> 2);
    endfunction

    // Slave: decide handshakes from mid-cycle values, update after the edge; R follows AR by one cycle.
    logic [15:0] rq[$];
    bit          ar_take, r_take;
    logic [15:0] take_addr;
    always begin
        @(negedge clk);
        ar_take   = arvalid && arready;
        r_take    = rvalid && rready;
        take_addr = araddr;
        @(posedge clk);
        #2;
        if (!rst) rq.delete();
        else begin
            if (r_take && rq.size() > 0) void'(rq.pop_front());
            if (ar_take) rq.push_back(take_addr);
        end
        rvalid = r_en && rq.size() > 0;
        if (rq.size() > 0) begin
            rdata = 32'hA0 + 32'(idx(rq[0]));
            rresp = idx(rq[0]) == err_idx ? 2'd2 : 2'd0;
        end
    end

    always @(negedge clk) begin
        if (rst && arvalid && arready) begin
            ar_cnt++;
            if (err) ar_after_err++;
            if (ar_chk) begin
                if (exp_ar.size() == 0) chk("ar_extra", 1, 0);
                else chk("araddr", araddr, exp_ar.pop_front());
            end
        end
        if (rst && out_valid && out_ready) begin
            if (exp_out.size() == 0) chk("out_extra", 1, 0);
            else begin
                beat_t b;
                b = exp_out.pop_front();
                chk("out_data", out_data, b.d);
                chk("out_resp", out_resp, b.r);
                chk("out_last", out_last, b.l);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [15:0] a, input int n);
        beat_t b;
        cur_base = a;
        for (int i = 0; i < n; i++) begin
            exp_ar.push_back(a + 16'(i * 4));
            b.d = 32'hA0 + 32'(i);
            b.r = i == err_idx ? 2'd2 : 2'd0;
            b.l = i == n - 1;
            exp_out.push_back(b);
        end
    endtask

    task automatic start_cmd(input logic [15:0] a, input logic [7:0] n);
        start_addr  = a;
        start_count = n;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        forever begin
            @(negedge clk);
            if (busy) bc++;
            if (done) break;
            lat++;
            if (lat > 300) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic after_done();
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("start_ready_back", start_ready, 1);
        chk("sb_out_empty", exp_out.size(), 0);
        chk("sb_ar_empty", exp_ar.size(), 0);
    endtask

    initial begin
        int lat, bc, a0, wt;
        #12;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rready", rready, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_start_ready", start_ready, 1);
        chk("rst_err", err, 0);

        push_cmd(16'h0100, 4);
        start_cmd(16'h0100, 4);
        wait_done(lat, bc);
        chk("lat_n4", lat, 7);
        chk("err_clean", err, 0);
        after_done();

        tick();
        push_cmd(16'hFFFC, 2);
        start_cmd(16'hFFFC, 2);
        wait_done(lat, bc);
        chk("lat_wrap", lat, 5);
        after_done();

        tick();
        a0 = ar_cnt;
        start_cmd(16'h0500, 0);
        wait_done(lat, bc);
        chk("lat_zero", lat, 1);
        chk("busy_zero", bc, 1);
        chk("ar_zero", ar_cnt - a0, 0);
        after_done();

        tick();
        r_en = 1'b0;
        a0 = ar_cnt;
        push_cmd(16'h0200, 8);
        start_cmd(16'h0200, 8);
        repeat (20) tick();
        chk("stall_ar_cnt", ar_cnt - a0, 4);
        chk("stall_arvalid", arvalid, 0);
        r_en = 1'b1;
        wait_done(lat, bc);
        after_done();

        tick();
        out_ready = 1'b0;
        push_cmd(16'h0100, 4);
        start_cmd(16'h0100, 4);
        wt = 0;
        do begin
            @(negedge clk);
            wt++;
        end while (!out_valid && wt < 50);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", out_data, 32'hA0);
            chk("bp_rready", rready, 0);
            @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        wait_done(lat, bc);
        after_done();

        tick();
        err_idx = 1;
        ar_after_err = 0;
`ifdef AXIL_READ_ERR_ABORT_EN
        begin
            beat_t b;
            ar_chk = 1'b0;
            cur_base = 16'h0100;
            b.d = 32'hA0; b.r = 2'd0; b.l = 1'b0; exp_out.push_back(b);
            b.d = 32'hA1; b.r = 2'd2; b.l = 1'b1; exp_out.push_back(b);
        end
`else
        push_cmd(16'h0100, 4);
`endif
        start_cmd(16'h0100, 4);
        wait_done(lat, bc);
        chk("err_set", err, 1);
`ifdef AXIL_READ_ERR_ABORT_EN
        chk("ar_after_err", ar_after_err, 0);
`endif
        after_done();
        err_idx = -1;
        ar_chk = 1'b1;

        tick();
        push_cmd(16'h0300, 8);
        start_cmd(16'h0300, 8);
        chk("err_cleared", err, 0);
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_arvalid", arvalid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        exp_out.delete();
        exp_ar.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        push_cmd(16'h0040, 4);
        start_cmd(16'h0040, 4);
        wait_done(lat, bc);
        chk("lat_after_rst", lat, 7);
        after_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
